reg_file: RTL and testbench
===========================

# reg_file

Architectural register file with rename tags for the out-of-order RV32I core. It sits between Decoder and RoB. On issue it records which RoB entry will produce each destination register. On commit it writes the final value and releases the tag. It answers the Decoder's two source-operand lookups in the same cycle, resolving each operand to a value or a RoB tag, with forwarding from the RoB and from the committing instruction.

## Interface
Parameters:
- ROB_SIZE_WIDTH, default 4: width of RoB entry index.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global stall-release; state updates only when high.
- clear  in  1  RoB flush (mispredict); drops all pending tags.
- issue_valid  in  1  an instruction with a register destination is issued this cycle.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_rob_id  in  ROB_SIZE_WIDTH  RoB entry allocated to it.
- commit_valid  in  1  RoB head commits a register write this cycle.
- commit_rd  in  5  destination register of the commit.
- commit_rob_id  in  ROB_SIZE_WIDTH  RoB entry being committed.
- commit_value  in  32  result being committed.
- rs1, rs2  in  5 each  source registers from Decoder.
- val1, val2  out  32 each  operand value; valid when the matching dep bit is 0.
- dep1, dep2  out  1 each  operand still pending in the RoB.
- tag1, tag2  out  ROB_SIZE_WIDTH each  RoB entry to wait on when the dep bit is 1.
- get_rob_id1, get_rob_id2  out  ROB_SIZE_WIDTH each  tag queried in the RoB; equals tag1/tag2 of the register lookup.
- get_ready1, get_ready2  in  1 each  RoB has the value for the queried tag.
- get_value1, get_value2  in  32 each  the RoB value.

## Operation
- State per register i in 0..31:
  - value[i], 32 bits.
  - busy[i], 1 bit.
  - tag[i], ROB_SIZE_WIDTH bits.
- x0 is hard-wired. value[0]=0 and busy[0]=0 always. Issue and commit to rd=0 are ignored.
- Issue, when rdy && issue_valid && !clear && issue_rd!=0: busy[rd] <= 1 and tag[rd] <= issue_rob_id.
- Commit, when rdy && commit_valid && commit_rd!=0:
  - value[rd] <= commit_value.
  - If busy[rd] && tag[rd]==commit_rob_id, then busy[rd] <= 0.
  - If tag[rd] differs (a younger writer exists), busy and tag are untouched.
- Issue and commit to the same rd in the same cycle: the value is written, and busy stays 1 with tag = issue_rob_id (the issue wins).
- Clear with rdy: all busy <= 0, tags unchanged. A commit in the same cycle still writes its value. Issue is ignored.
- rdy low: no state change. Outputs keep following their inputs combinationally.
- Operand lookup for port k (same rules for port 2), first match wins:
  1. rsk==0 → val=0, dep=0.
  2. !busy[rsk] → val=value[rsk], dep=0.
  3. commit_valid && commit_rd==rsk && commit_rob_id==tag[rsk] → val=commit_value, dep=0.
  4. get_readyk → val=get_valuek, dep=0.
  5. Otherwise → dep=1, tag=tag[rsk], val=0.
- get_rob_idk = tag[rsk] always.
- Lookups reflect state before this cycle's issue. An instruction reading its own rd sees the previous producer.
- tag outputs are don't-care when dep=0; drive tag[rsk].

## Timing
- Lookup is zero-latency combinational, including the RoB round-trip (get_rob_id → get_ready/get_value).
- Issue and commit state updates are visible to lookups from the next cycle. The same-cycle commit is covered by bypass rule 3.
- Reset, applied at a clock edge with rst=1: all value=0, busy=0, tag=0. Outputs then read val=0, dep=0, tag=0.
- Reset mid-operation discards all pending tags. rst takes priority over rdy, clear, issue and commit.
- No handshake back-pressure. The block accepts one issue and one commit per cycle unconditionally.

## Structure
- ROB_SIZE_WIDTH and instruction-type codes come from the shared config.v. No new typedefs are needed.
- A single module; no sub-module. The two lookup ports are one repeated combinational function, written as a generate loop or a pair of identical always blocks.

## Test plan
- Reset, then rs1=5, rs2=0 → val1=0, dep1=0, val2=0, dep2=0.
- Issue rd=5 with rob 3. Next cycle rs1=5 with get_ready1=0 → dep1=1, tag1=3, get_rob_id1=3. Then commit rd=5, rob 3, value 0xDEADBEEF in the same cycle as the lookup → dep1=0, val1=0xDEADBEEF. Following cycle busy[5]=0 and value 0xDEADBEEF.
- Issue rd=7 with rob 1, then rob 2. Commit rd=7 rob 1 value 0x11 → value[7]=0x11, busy[7]=1, tag 2. Lookup rs2=7 → dep2=1, tag2=2.
- Issue rd=9 with rob 4. RoB answers get_ready1=1, get_value1=0x1234 for rs1=9 → dep1=0, val1=0x1234, while busy[9] stays 1.
- Issue rd=3/rob 5 and rd=4/rob 6, then assert clear with an issue of rd=6/rob 7 → next cycle busy all 0. rs1=6 returns the old value with dep1=0.
- Issue or commit rd=0 with value 0xFF → rs1=0 returns val1=0, dep1=0. Holding rdy=0 during an issue → no busy bit set.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants for the architectural register file.
//               Holds the architectural widths and the default RoB index
//               width used by the interface and the register file.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int NUM_REGS               = 32;
    localparam int REG_ADDR_W             = 5;
    localparam int XLEN                   = 32;
    localparam int DEFAULT_ROB_SIZE_WIDTH = 4;
    localparam int NUM_LOOKUP_PORTS       = 2;

endpackage

`default_nettype wire

// File: rtl/reg_file_if.sv
// ============================================================================
// Module      : reg_file_if
// Description : Bundle of the issue, commit, clear, operand-lookup and RoB
//               query signals between Decoder/RoB (master) and the register
//               file (slave).
// Ports       : none (all signals are interface members)
//               master drives rdy, clear, issue_*, commit_*, rs1/rs2,
//               get_ready*/get_value*; slave drives val*, dep*, tag*,
//               get_rob_id*.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH = DEFAULT_ROB_SIZE_WIDTH
);

    logic                      rdy;
    logic                      clear;

    logic                      issue_valid;
    logic [REG_ADDR_W-1:0]     issue_rd;
    logic [ROB_SIZE_WIDTH-1:0] issue_rob_id;

    logic                      commit_valid;
    logic [REG_ADDR_W-1:0]     commit_rd;
    logic [ROB_SIZE_WIDTH-1:0] commit_rob_id;
    logic [XLEN-1:0]           commit_value;

    logic [REG_ADDR_W-1:0]     rs1;
    logic [REG_ADDR_W-1:0]     rs2;
    logic [XLEN-1:0]           val1;
    logic [XLEN-1:0]           val2;
    logic                      dep1;
    logic                      dep2;
    logic [ROB_SIZE_WIDTH-1:0] tag1;
    logic [ROB_SIZE_WIDTH-1:0] tag2;

    logic [ROB_SIZE_WIDTH-1:0] get_rob_id1;
    logic [ROB_SIZE_WIDTH-1:0] get_rob_id2;
    logic                      get_ready1;
    logic                      get_ready2;
    logic [XLEN-1:0]           get_value1;
    logic [XLEN-1:0]           get_value2;

    modport master (
        output rdy, clear,
        output issue_valid, issue_rd, issue_rob_id,
        output commit_valid, commit_rd, commit_rob_id, commit_value,
        output rs1, rs2,
        input  val1, val2, dep1, dep2, tag1, tag2,
        input  get_rob_id1, get_rob_id2,
        output get_ready1, get_ready2, get_value1, get_value2
    );

    modport slave (
        input  rdy, clear,
        input  issue_valid, issue_rd, issue_rob_id,
        input  commit_valid, commit_rd, commit_rob_id, commit_value,
        input  rs1, rs2,
        output val1, val2, dep1, dep2, tag1, tag2,
        output get_rob_id1, get_rob_id2,
        input  get_ready1, get_ready2, get_value1, get_value2
    );

endinterface

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : Architectural register file with RoB rename tags. Issue marks
//               a destination busy with its producing RoB entry; commit writes
//               the final value and releases the tag if it still names the
//               committing entry. Two combinational operand lookups resolve
//               each source to a value or a RoB tag, forwarding from the
//               committing instruction and from the RoB.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               bus  - reg_file_if.slave (issue/commit/clear/lookup/RoB query)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH = DEFAULT_ROB_SIZE_WIDTH
)
(
    input  logic      clk,
    input  logic      rst,
    reg_file_if.slave bus
);

    logic [XLEN-1:0]           r_value [NUM_REGS];
    logic [ROB_SIZE_WIDTH-1:0] r_tag   [NUM_REGS];
    logic [NUM_REGS-1:0]       r_busy;

    logic w_issue_en;
    logic w_commit_en;
    logic w_clear_en;

    // Writes to x0 are dropped here, so entry 0 stays at its reset value.
    assign w_issue_en  = bus.rdy && bus.issue_valid && !bus.clear && (bus.issue_rd != '0);
    assign w_commit_en = bus.rdy && bus.commit_valid && (bus.commit_rd != '0);
    assign w_clear_en  = bus.rdy && bus.clear;

    // Statement order encodes priority: the issue's busy/tag update is placed
    // after the commit release so a same-cycle issue to the same rd wins, and
    // the flush overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_commit_en) begin
                r_value[bus.commit_rd] <= bus.commit_value;
                if (r_busy[bus.commit_rd] && (r_tag[bus.commit_rd] == bus.commit_rob_id)) begin
                    r_busy[bus.commit_rd] <= 1'b0;
                end
            end
            if (w_clear_en) begin
                r_busy <= '0;
            end else if (w_issue_en) begin
                r_busy[bus.issue_rd] <= 1'b1;
                r_tag[bus.issue_rd]  <= bus.issue_rob_id;
            end
        end
    end

    // Identical lookup for both source ports; k selects which port's signals.
    for (genvar k = 0; k < NUM_LOOKUP_PORTS; k++) begin : g_lookup
        logic [REG_ADDR_W-1:0]     w_rs;
        logic                      w_rob_ready;
        logic [XLEN-1:0]           w_rob_value;
        logic [ROB_SIZE_WIDTH-1:0] w_tag;
        logic [XLEN-1:0]           w_val;
        logic                      w_dep;

        assign w_rs        = (k == 0) ? bus.rs1        : bus.rs2;
        assign w_rob_ready = (k == 0) ? bus.get_ready1 : bus.get_ready2;
        assign w_rob_value = (k == 0) ? bus.get_value1 : bus.get_value2;
        assign w_tag       = r_tag[w_rs];

        always_comb begin
            w_val = '0;
            w_dep = 1'b0;
            if (w_rs == '0) begin
                w_val = '0;
            end else if (!r_busy[w_rs]) begin
                w_val = r_value[w_rs];
            end else if (bus.commit_valid && (bus.commit_rd == w_rs)
                         && (bus.commit_rob_id == w_tag)) begin
                // Producer commits this very cycle; its value is not yet in
                // the array, so take it straight off the commit bus.
                w_val = bus.commit_value;
            end else if (w_rob_ready) begin
                w_val = w_rob_value;
            end else begin
                w_dep = 1'b1;
            end
        end
    end

    assign bus.val1        = g_lookup[0].w_val;
    assign bus.dep1        = g_lookup[0].w_dep;
    assign bus.tag1        = g_lookup[0].w_tag;
    assign bus.get_rob_id1 = g_lookup[0].w_tag;

    assign bus.val2        = g_lookup[1].w_val;
    assign bus.dep2        = g_lookup[1].w_dep;
    assign bus.tag2        = g_lookup[1].w_tag;
    assign bus.get_rob_id2 = g_lookup[1].w_tag;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file: directed scenarios followed
//               by randomized traffic compared against a behavioural model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

    localparam int RW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_file_if #(.ROB_SIZE_WIDTH(RW)) bus ();

    reg_file #(.ROB_SIZE_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: one entry per architectural register.
    logic [31:0]   m_value [32];
    logic          m_busy  [32];
    logic [RW-1:0] m_tag   [32];

    // Advance the reference state by one clock using the current inputs,
    // then cross the edge and return at the following falling edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_value[i] = 32'h0;
                m_busy[i]  = 1'b0;
                m_tag[i]   = '0;
            end
        end else if (bus.rdy) begin
            if (bus.commit_valid && bus.commit_rd != 5'd0) begin
                m_value[bus.commit_rd] = bus.commit_value;
                if (m_busy[bus.commit_rd] && m_tag[bus.commit_rd] == bus.commit_rob_id)
                    m_busy[bus.commit_rd] = 1'b0;
            end
            if (bus.clear) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (bus.issue_valid && bus.issue_rd != 5'd0) begin
                m_busy[bus.issue_rd] = 1'b1;
                m_tag[bus.issue_rd]  = bus.issue_rob_id;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Operand resolution rules, first match wins.
    function automatic void exp_port(input logic [4:0] rs, input logic gr, input logic [31:0] gv,
                                     output logic [31:0] v, output logic d, output logic [RW-1:0] t);
        t = m_tag[rs];
        d = 1'b0;
        v = 32'h0;
        if (rs == 5'd0)               v = 32'h0;
        else if (!m_busy[rs])         v = m_value[rs];
        else if (bus.commit_valid && bus.commit_rd == rs && bus.commit_rob_id == m_tag[rs])
                                      v = bus.commit_value;
        else if (gr)                  v = gv;
        else                          d = 1'b1;
    endfunction

    task automatic idle_inputs();
        bus.rdy = 1'b1;      bus.clear = 1'b0;
        bus.issue_valid = 0; bus.issue_rd = 0; bus.issue_rob_id = 0;
        bus.commit_valid = 0; bus.commit_rd = 0; bus.commit_rob_id = 0; bus.commit_value = 0;
        bus.rs1 = 0; bus.rs2 = 0;
        bus.get_ready1 = 0; bus.get_ready2 = 0; bus.get_value1 = 0; bus.get_value2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.rs1 = 5'd5; bus.rs2 = 5'd0;
        #1;
        checks++;
        if (bus.val1 !== 32'h0 || bus.dep1 !== 1'b0 || bus.tag1 !== 4'd0 || bus.get_rob_id1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_port1: got val=%h dep=%b tag=%h gid=%h expected val=0 dep=0 tag=0 gid=0",
                     bus.val1, bus.dep1, bus.tag1, bus.get_rob_id1);
        end
        checks++;
        if (bus.val2 !== 32'h0 || bus.dep2 !== 1'b0 || bus.tag2 !== 4'd0) begin
            errors++;
            $display("FAIL reset_port2: got val=%h dep=%b tag=%h expected val=0 dep=0 tag=0",
                     bus.val2, bus.dep2, bus.tag2);
        end
    endtask

    task automatic test_issue_commit();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_rd = 5'd5; bus.issue_rob_id = 4'd3;
        tick();
        idle_inputs();
        bus.rs1 = 5'd5;
        #1;
        checks++;
        if (bus.dep1 !== 1'b1 || bus.tag1 !== 4'd3 || bus.get_rob_id1 !== 4'd3) begin
            errors++;
            $display("FAIL pending_tag: got dep=%b tag=%h gid=%h expected dep=1 tag=3 gid=3",
                     bus.dep1, bus.tag1, bus.get_rob_id1);
        end
        bus.commit_valid = 1; bus.commit_rd = 5'd5; bus.commit_rob_id = 4'd3;
        bus.commit_value = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.dep1 !== 1'b0 || bus.val1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL commit_bypass: got dep=%b val=%h expected dep=0 val=deadbeef", bus.dep1, bus.val1);
        end
        tick();
        idle_inputs();
        bus.rs1 = 5'd5;
        #1;
        checks++;
        if (bus.dep1 !== 1'b0 || bus.val1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL commit_written: got dep=%b val=%h expected dep=0 val=deadbeef", bus.dep1, bus.val1);
        end
    endtask

    task automatic test_younger_writer();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_rd = 5'd7; bus.issue_rob_id = 4'd1;
        tick();
        bus.issue_rob_id = 4'd2;
        tick();
        idle_inputs();
        bus.commit_valid = 1; bus.commit_rd = 5'd7; bus.commit_rob_id = 4'd1; bus.commit_value = 32'h11;
        tick();
        idle_inputs();
        bus.rs2 = 5'd7;
        #1;
        checks++;
        if (bus.dep2 !== 1'b1 || bus.tag2 !== 4'd2) begin
            errors++;
            $display("FAIL younger_writer: got dep=%b tag=%h expected dep=1 tag=2", bus.dep2, bus.tag2);
        end
        bus.commit_valid = 1; bus.commit_rd = 5'd7; bus.commit_rob_id = 4'd2; bus.commit_value = 32'h22;
        tick();
        idle_inputs();
        bus.rs2 = 5'd7;
        #1;
        checks++;
        if (bus.dep2 !== 1'b0 || bus.val2 !== 32'h22) begin
            errors++;
            $display("FAIL younger_commit: got dep=%b val=%h expected dep=0 val=22", bus.dep2, bus.val2);
        end
    endtask

    task automatic test_rob_forward();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_rd = 5'd9; bus.issue_rob_id = 4'd4;
        tick();
        idle_inputs();
        bus.rs1 = 5'd9; bus.get_ready1 = 1; bus.get_value1 = 32'h1234;
        #1;
        checks++;
        if (bus.dep1 !== 1'b0 || bus.val1 !== 32'h1234 || bus.get_rob_id1 !== 4'd4) begin
            errors++;
            $display("FAIL rob_forward: got dep=%b val=%h gid=%h expected dep=0 val=1234 gid=4",
                     bus.dep1, bus.val1, bus.get_rob_id1);
        end
        tick();
        bus.get_ready1 = 0;
        #1;
        checks++;
        if (bus.dep1 !== 1'b1 || bus.tag1 !== 4'd4) begin
            errors++;
            $display("FAIL rob_forward_busy: got dep=%b tag=%h expected dep=1 tag=4", bus.dep1, bus.tag1);
        end
    endtask

    task automatic test_same_cycle_issue_commit();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_rd = 5'd11; bus.issue_rob_id = 4'd3;
        tick();
        bus.issue_rob_id = 4'd5;
        bus.commit_valid = 1; bus.commit_rd = 5'd11; bus.commit_rob_id = 4'd3; bus.commit_value = 32'hAB;
        tick();
        idle_inputs();
        bus.rs1 = 5'd11;
        #1;
        checks++;
        if (bus.dep1 !== 1'b1 || bus.tag1 !== 4'd5) begin
            errors++;
            $display("FAIL issue_wins: got dep=%b tag=%h expected dep=1 tag=5", bus.dep1, bus.tag1);
        end
        bus.commit_valid = 1; bus.commit_rd = 5'd11; bus.commit_rob_id = 4'd5; bus.commit_value = 32'hCD;
        #1;
        checks++;
        if (bus.dep1 !== 1'b0 || bus.val1 !== 32'hCD) begin
            errors++;
            $display("FAIL issue_wins_bypass: got dep=%b val=%h expected dep=0 val=cd", bus.dep1, bus.val1);
        end
        tick();
    endtask

    task automatic test_clear();
        idle_inputs();
        bus.commit_valid = 1; bus.commit_rd = 5'd6; bus.commit_rob_id = 4'd0; bus.commit_value = 32'h66;
        tick();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_rd = 5'd3; bus.issue_rob_id = 4'd5;
        tick();
        bus.issue_rd = 5'd4; bus.issue_rob_id = 4'd6;
        tick();
        bus.clear = 1; bus.issue_rd = 5'd6; bus.issue_rob_id = 4'd7;
        tick();
        idle_inputs();
        bus.rs1 = 5'd6; bus.rs2 = 5'd4;
        #1;
        checks++;
        if (bus.dep1 !== 1'b0 || bus.val1 !== 32'h66) begin
            errors++;
            $display("FAIL clear_issue_dropped: got dep=%b val=%h expected dep=0 val=66", bus.dep1, bus.val1);
        end
        checks++;
        if (bus.dep2 !== 1'b0 || bus.val2 !== 32'h0 || bus.tag2 !== 4'd6) begin
            errors++;
            $display("FAIL clear_busy: got dep=%b val=%h tag=%h expected dep=0 val=0 tag=6",
                     bus.dep2, bus.val2, bus.tag2);
        end
    endtask

    task automatic test_x0_and_stall();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_rd = 5'd0; bus.issue_rob_id = 4'd5;
        bus.commit_valid = 1; bus.commit_rd = 5'd0; bus.commit_value = 32'hFF;
        tick();
        idle_inputs();
        bus.rs1 = 5'd0;
        #1;
        checks++;
        if (bus.val1 !== 32'h0 || bus.dep1 !== 1'b0) begin
            errors++;
            $display("FAIL x0_hardwired: got val=%h dep=%b expected val=0 dep=0", bus.val1, bus.dep1);
        end
        bus.rdy = 0;
        bus.issue_valid = 1; bus.issue_rd = 5'd10; bus.issue_rob_id = 4'd2;
        bus.commit_valid = 1; bus.commit_rd = 5'd12; bus.commit_value = 32'h77;
        tick();
        idle_inputs();
        bus.rs1 = 5'd10; bus.rs2 = 5'd12;
        #1;
        checks++;
        if (bus.dep1 !== 1'b0 || bus.val2 !== 32'h0) begin
            errors++;
            $display("FAIL stall_no_update: got dep1=%b val2=%h expected dep1=0 val2=0", bus.dep1, bus.val2);
        end
    endtask

    task automatic test_random();
        logic [31:0]   ev;
        logic          ed;
        logic [RW-1:0] et;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst               = ($urandom_range(0, 99) == 0);
            bus.rdy           = ($urandom_range(0, 7) != 0);
            bus.clear         = ($urandom_range(0, 19) == 0);
            bus.issue_valid   = $urandom_range(0, 1);
            bus.issue_rd      = 5'($urandom_range(0, 7));
            bus.issue_rob_id  = RW'($urandom);
            bus.commit_valid  = $urandom_range(0, 1);
            bus.commit_rd     = 5'($urandom_range(0, 7));
            bus.commit_rob_id = $urandom_range(0, 1) ? m_tag[bus.commit_rd] : RW'($urandom);
            bus.commit_value  = $urandom;
            bus.rs1           = 5'($urandom_range(0, 7));
            bus.rs2           = 5'($urandom_range(0, 7));
            bus.get_ready1    = ($urandom_range(0, 3) == 0);
            bus.get_ready2    = ($urandom_range(0, 3) == 0);
            bus.get_value1    = $urandom;
            bus.get_value2    = $urandom;
            #1;
            exp_port(bus.rs1, bus.get_ready1, bus.get_value1, ev, ed, et);
            checks++;
            if (bus.val1 !== ev || bus.dep1 !== ed || bus.tag1 !== et || bus.get_rob_id1 !== et) begin
                errors++;
                $display("FAIL rand_port1 cyc %0d: got val=%h dep=%b tag=%h gid=%h expected val=%h dep=%b tag=%h",
                         n, bus.val1, bus.dep1, bus.tag1, bus.get_rob_id1, ev, ed, et);
            end
            exp_port(bus.rs2, bus.get_ready2, bus.get_value2, ev, ed, et);
            checks++;
            if (bus.val2 !== ev || bus.dep2 !== ed || bus.tag2 !== et || bus.get_rob_id2 !== et) begin
                errors++;
                $display("FAIL rand_port2 cyc %0d: got val=%h dep=%b tag=%h gid=%h expected val=%h dep=%b tag=%h",
                         n, bus.val2, bus.dep2, bus.tag2, bus.get_rob_id2, ev, ed, et);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_issue_commit();
        test_younger_writer();
        test_rob_forward();
        test_same_cycle_issue_commit();
        test_clear();
        test_x0_and_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
